branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters for the 5-stage pipelined ARM core. The fetch stage looks up PCF each cycle to obtain a predicted next PC. The execute stage reports resolved branches to train the table and to flag mispredictions, so the hazard unit can flush D/E. It replaces "branch resolved in E, always predict not-taken" and adds hit/misprediction statistics for debug.

## Interface
Parameters:
- WIDTH, 32, address/data width
- INDEX_BITS, 4, log2 of entry count (16 entries); tag = PC[WIDTH-1:INDEX_BITS+2]
- STAT_WIDTH, 16, width of statistics counters

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high; clears table and statistics
- PCF  input  WIDTH  fetch-stage PC to look up
- PredTakenF  output  1  lookup hit and counter MSB = 1
- PredTargetF  output  WIDTH  predicted next PC: stored target if PredTakenF, else PCF+4
- UpdateE  input  1  a branch instruction is valid in E this cycle (condition evaluated)
- PCE  input  WIDTH  PC of the branch in E
- BranchTakenE  input  1  resolved direction
- BranchTargetE  input  WIDTH  resolved target (ALUResultE)
- PredTakenE  input  1  PredTakenF carried down the pipeline with the branch
- PredTargetE  input  WIDTH  PredTargetF carried down with the branch
- MispredictE  output  1  prediction wrong; hazard unit flushes D and E
- RecoverPCE  output  WIDTH  correct next PC: BranchTargetE if taken, else PCE+4
- StatLookups  output  STAT_WIDTH  count of UpdateE cycles
- StatMispredicts  output  STAT_WIDTH  count of MispredictE cycles

## Operation
- Entry: valid (1), tag, target (WIDTH), counter (2). PC[1:0] ignored; index = PC[INDEX_BITS+1:2].
- Lookup (combinational from registered state): hit = valid[idx] & tag match. PredTakenF = hit & ctr[1].
- MispredictE = UpdateE & ((PredTakenE != BranchTakenE) | (BranchTakenE & PredTakenE & PredTargetE != BranchTargetE)). Zero when UpdateE = 0.
- Training on rising clk when UpdateE = 1:
  - Hit, taken: ctr saturating +1 (max 11), target <= BranchTargetE.
  - Hit, not taken: ctr saturating -1 (min 00). Entry stays valid.
  - Miss, taken: allocate/overwrite: valid=1, tag, target, ctr=10 (weakly taken).
  - Miss, not taken: no table change.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Transitions are +1 on taken and -1 on not taken, saturating at both ends.
- Statistics: StatLookups +1 per UpdateE; StatMispredicts +1 per MispredictE. Both saturate at all-ones and do not wrap.
- Arithmetic: PC+4 modulo 2^WIDTH (wraps at all-ones without error).

## Timing
- Lookup latency 0 cycles (combinational from PCF). Training visible to a lookup on the cycle after the update edge.
- Simultaneous lookup and update of the same index: lookup returns pre-update contents (no bypass).
- MispredictE and RecoverPCE are combinational in the same cycle as UpdateE. The flush/redirect is registered by the pipeline, not here.
- Reset (synchronous, any cycle including mid-training): all valid=0, all ctr=01, targets/tags=0, statistics=0. Updates presented in the reset cycle are discarded.
- Outputs after reset: PredTakenF=0, PredTargetF=PCF+4, MispredictE=0 (if UpdateE=0), StatLookups=StatMispredicts=0.
- Stall: not an input. The pipeline holds PCF stable during StallF, so the lookup repeats identically. UpdateE must be deasserted for flushed/bubbled E slots.

## Test plan
- Reset, then PCF=0x20 -> PredTakenF=0, PredTargetF=0x24. Both stats = 0.
- UpdateE with PCE=0x20, taken, target 0x80, PredTakenE=0 -> MispredictE=1, RecoverPCE=0x80. Next cycle PCF=0x20 gives PredTakenF=1, PredTargetF=0x80, StatMispredicts=1.
- Same branch: taken twice then not-taken three times -> ctr goes 10→11→11→10→01→00. PredTakenF flips to 0 after the second not-taken. Entry remains valid.
- Alias: PCE=0x60 (same index as 0x20 for INDEX_BITS=4), taken, target 0x100 -> PCF=0x20 then misses (PredTargetF=0x24), and PCF=0x60 hits.
- Predicted taken to 0x80 but resolved taken to 0x90 -> MispredictE=1, RecoverPCE=0x90, stored target becomes 0x90.
- Assert reset mid-sequence after training -> every lookup misses next cycle. Stats read 0. With STAT_WIDTH=2, four mispredicts hold StatMispredicts at 3.

Source files
------------

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup and execute training bus for the branch target buffer
//
// Purpose : groups the fetch-stage lookup and execute-stage resolution signals
//           shared between the pipeline and the branch target buffer.
// Ports   : PCF/PredTakenF/PredTargetF            fetch-stage lookup
//           UpdateE/PCE/BranchTakenE/BranchTargetE resolved branch in E
//           PredTakenE/PredTargetE                 prediction carried with the branch
//           MispredictE/RecoverPCE                 redirect request to the hazard unit
//           StatLookups/StatMispredicts            saturating debug counters
// Modports: master = pipeline side, slave = branch target buffer side.
interface branch_target_buffer_if #(
    parameter int WIDTH      = 32,
    parameter int STAT_WIDTH = 16
);
    logic [WIDTH-1:0]      PCF;
    logic                  PredTakenF;
    logic [WIDTH-1:0]      PredTargetF;
    logic                  UpdateE;
    logic [WIDTH-1:0]      PCE;
    logic                  BranchTakenE;
    logic [WIDTH-1:0]      BranchTargetE;
    logic                  PredTakenE;
    logic [WIDTH-1:0]      PredTargetE;
    logic                  MispredictE;
    logic [WIDTH-1:0]      RecoverPCE;
    logic [STAT_WIDTH-1:0] StatLookups;
    logic [STAT_WIDTH-1:0] StatMispredicts;

    modport master (
        output PCF, UpdateE, PCE, BranchTakenE, BranchTargetE, PredTakenE, PredTargetE,
        input  PredTakenF, PredTargetF, MispredictE, RecoverPCE, StatLookups, StatMispredicts
    );

    modport slave (
        input  PCF, UpdateE, PCE, BranchTakenE, BranchTargetE, PredTakenE, PredTargetE,
        output PredTakenF, PredTargetF, MispredictE, RecoverPCE, StatLookups, StatMispredicts
    );
endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with 2-bit direction counters
//
// Purpose : predicts the next fetch PC from PCF and trains on branches resolved
//           in E, flagging mispredictions so the hazard unit can flush D/E.
// Ports   : clk   - rising-edge clock
//           reset - synchronous active-high; clears table and statistics
//           bus   - slave side of branch_target_buffer_if (lookup, training,
//                   redirect and statistics signals). The interface WIDTH and
//                   STAT_WIDTH must match the parameters of this module.
module branch_target_buffer #(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_target_buffer_if.slave  bus
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = WIDTH - INDEX_BITS - 2;

    logic                  valid_mem  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_mem    [ENTRIES];
    logic [WIDTH-1:0]      target_mem [ENTRIES];
    logic [1:0]            ctr_mem    [ENTRIES];
    logic [STAT_WIDTH-1:0] stat_lookups;
    logic [STAT_WIDTH-1:0] stat_mispredicts;

    // Byte offset within the word never selects an entry.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{bus.PCF[1:0], bus.PCE[1:0]};

    // Fetch-side lookup: purely combinational from the registered table, so
    // a same-cycle update to the same index is not seen until the next cycle.
    logic [INDEX_BITS-1:0] idx_f;
    logic [TAG_BITS-1:0]   tag_f;
    logic                  hit_f;

    assign idx_f = bus.PCF[INDEX_BITS+1:2];
    assign tag_f = bus.PCF[WIDTH-1:INDEX_BITS+2];
    assign hit_f = valid_mem[idx_f] && (tag_mem[idx_f] == tag_f);

    assign bus.PredTakenF  = hit_f && ctr_mem[idx_f][1];
    assign bus.PredTargetF = bus.PredTakenF ? target_mem[idx_f] : bus.PCF + WIDTH'(4);

    // Execute-side resolution.
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_e;
    logic                  hit_e;
    logic                  dir_wrong;
    logic                  target_wrong;

    assign idx_e = bus.PCE[INDEX_BITS+1:2];
    assign tag_e = bus.PCE[WIDTH-1:INDEX_BITS+2];
    assign hit_e = valid_mem[idx_e] && (tag_mem[idx_e] == tag_e);

    // A correctly predicted taken branch can still go to a different target
    // (e.g. register-indirect), which also needs a redirect.
    assign dir_wrong    = bus.PredTakenE != bus.BranchTakenE;
    assign target_wrong = bus.BranchTakenE && bus.PredTakenE &&
                          (bus.PredTargetE != bus.BranchTargetE);

    assign bus.MispredictE = bus.UpdateE && (dir_wrong || target_wrong);
    assign bus.RecoverPCE  = bus.BranchTakenE ? bus.BranchTargetE : bus.PCE + WIDTH'(4);

    assign bus.StatLookups     = stat_lookups;
    assign bus.StatMispredicts = stat_mispredicts;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_mem[i]  <= 1'b0;
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                ctr_mem[i]    <= 2'b01;
            end
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else if (bus.UpdateE) begin
            if (hit_e) begin
                if (bus.BranchTakenE) begin
                    if (ctr_mem[idx_e] != 2'b11) begin
                        ctr_mem[idx_e] <= ctr_mem[idx_e] + 2'd1;
                    end
                    target_mem[idx_e] <= bus.BranchTargetE;
                end else if (ctr_mem[idx_e] != 2'b00) begin
                    ctr_mem[idx_e] <= ctr_mem[idx_e] - 2'd1;
                end
            end else if (bus.BranchTakenE) begin
                // Allocate weakly taken so one later not-taken flips the prediction.
                valid_mem[idx_e]  <= 1'b1;
                tag_mem[idx_e]    <= tag_e;
                target_mem[idx_e] <= bus.BranchTargetE;
                ctr_mem[idx_e]    <= 2'b10;
            end

            if (stat_lookups != '1) begin
                stat_lookups <= stat_lookups + STAT_WIDTH'(1);
            end
            if (bus.MispredictE && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - scoreboard bench for branch_target_buffer
module tb_branch_target_buffer;
    logic clk;
    logic reset;
    logic chk;

    branch_target_buffer_if #(.WIDTH(32), .STAT_WIDTH(16)) bus ();
    branch_target_buffer_if #(.WIDTH(32), .STAT_WIDTH(2))  bus_s ();

    branch_target_buffer #(.WIDTH(32), .INDEX_BITS(4), .STAT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    branch_target_buffer #(.WIDTH(32), .INDEX_BITS(4), .STAT_WIDTH(2)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    assign bus_s.PCF           = bus.PCF;
    assign bus_s.UpdateE       = bus.UpdateE;
    assign bus_s.PCE           = bus.PCE;
    assign bus_s.BranchTakenE  = bus.BranchTakenE;
    assign bus_s.BranchTargetE = bus.BranchTargetE;
    assign bus_s.PredTakenE    = bus.PredTakenE;
    assign bus_s.PredTargetE   = bus.PredTargetE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pt;
        logic [31:0] ptar;
        logic        mis;
        logic [31:0] rec;
        logic [15:0] lk;
        logic [15:0] ms;
        logic [1:0]  slk;
        logic [1:0]  sms;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   lk_cnt = 0;
    int   ms_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // Monitor: compares every cycle the bench marks as a presented response.
    always @(negedge clk) begin
        if (chk) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL scoreboard: response presented with no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("PredTakenF",       32'(bus.PredTakenF),        32'(e.pt));
                check("PredTargetF",      bus.PredTargetF,            e.ptar);
                check("MispredictE",      32'(bus.MispredictE),       32'(e.mis));
                check("RecoverPCE",       bus.RecoverPCE,             e.rec);
                check("StatLookups",      32'(bus.StatLookups),       32'(e.lk));
                check("StatMispredicts",  32'(bus.StatMispredicts),   32'(e.ms));
                check("SmallLookups",     32'(bus_s.StatLookups),     32'(e.slk));
                check("SmallMispredicts", 32'(bus_s.StatMispredicts), 32'(e.sms));
            end
        end
    end

    task automatic drive(input logic [31:0] pcf, input logic upd, input logic [31:0] pce,
                         input logic tk, input logic [31:0] btar, input logic ptk,
                         input logic [31:0] ptgt);
        bus.PCF           = pcf;
        bus.UpdateE       = upd;
        bus.PCE           = pce;
        bus.BranchTakenE  = tk;
        bus.BranchTargetE = btar;
        bus.PredTakenE    = ptk;
        bus.PredTargetE   = ptgt;
    endtask

    // One checked cycle: inputs, then hand-computed lookup/redirect results.
    task automatic step(input logic [31:0] pcf, input logic upd, input logic [31:0] pce,
                        input logic tk, input logic [31:0] btar, input logic ptk,
                        input logic [31:0] ptgt, input logic e_pt, input logic [31:0] e_ptar,
                        input logic e_mis, input logic [31:0] e_rec);
        exp_t e;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(pcf, upd, pce, tk, btar, ptk, ptgt);
        e.pt   = e_pt;
        e.ptar = e_ptar;
        e.mis  = e_mis;
        e.rec  = e_rec;
        e.lk   = 16'(lk_cnt);
        e.ms   = 16'(ms_cnt);
        e.slk  = (lk_cnt > 3) ? 2'd3 : 2'(lk_cnt);
        e.sms  = (ms_cnt > 3) ? 2'd3 : 2'(ms_cnt);
        exp_q.push_back(e);
        chk = 1'b1;
        if (upd) lk_cnt++;
        if (e_mis) ms_cnt++;
    endtask

    task automatic reset_cycle(input logic [31:0] pce, input logic tk, input logic [31:0] btar);
        @(posedge clk);
        #1;
        chk   = 1'b0;
        reset = 1'b1;
        drive(32'h20, 1'b1, pce, tk, btar, 1'b0, 32'h0);
        lk_cnt = 0;
        ms_cnt = 0;
    endtask

    initial begin
        chk   = 1'b0;
        reset = 1'b1;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);

        //    PCF           Upd PCE           Tk BranchTgt    PTk PredTgt      ePT ePredTgt   eMis eRecover
        step(32'h20,        0,  32'h0,        1, 32'h80,      0,  32'h0,       0,  32'h24,    0,   32'h80);
        step(32'h20,        1,  32'h20,       1, 32'h80,      0,  32'h24,      0,  32'h24,    1,   32'h80);
        step(32'h20,        0,  32'h0,        0, 32'h0,       0,  32'h0,       1,  32'h80,    0,   32'h4);
        step(32'h20,        1,  32'h20,       1, 32'h80,      1,  32'h80,      1,  32'h80,    0,   32'h80);
        step(32'h20,        1,  32'h20,       1, 32'h80,      1,  32'h80,      1,  32'h80,    0,   32'h80);
        step(32'h20,        1,  32'h20,       0, 32'h80,      1,  32'h80,      1,  32'h80,    1,   32'h24);
        step(32'h20,        1,  32'h20,       0, 32'h80,      1,  32'h80,      1,  32'h80,    1,   32'h24);
        step(32'h20,        1,  32'h20,       0, 32'h80,      0,  32'h24,      0,  32'h24,    0,   32'h24);
        step(32'h20,        0,  32'h0,        0, 32'h0,       0,  32'h0,       0,  32'h24,    0,   32'h4);
        // Entry still valid at ctr 00: a taken hit only reaches 01, so no taken prediction.
        step(32'h20,        1,  32'h20,       1, 32'h80,      0,  32'h24,      0,  32'h24,    1,   32'h80);
        step(32'h20,        0,  32'h0,        0, 32'h0,       0,  32'h0,       0,  32'h24,    0,   32'h4);
        // Alias 0x60 evicts 0x20.
        step(32'h60,        1,  32'h60,       1, 32'h100,     0,  32'h64,      0,  32'h64,    1,   32'h100);
        step(32'h20,        0,  32'h0,        0, 32'h0,       0,  32'h0,       0,  32'h24,    0,   32'h4);
        step(32'h60,        0,  32'h0,        0, 32'h0,       0,  32'h0,       1,  32'h100,   0,   32'h4);
        // Reallocate 0x20, then a taken branch to a new target.
        step(32'h20,        1,  32'h20,       1, 32'h80,      0,  32'h24,      0,  32'h24,    1,   32'h80);
        step(32'h20,        0,  32'h0,        0, 32'h0,       0,  32'h0,       1,  32'h80,    0,   32'h4);
        step(32'h20,        1,  32'h20,       1, 32'h90,      1,  32'h80,      1,  32'h80,    1,   32'h90);
        step(32'h20,        0,  32'h0,        0, 32'h0,       0,  32'h0,       1,  32'h90,    0,   32'h4);
        // PC+4 wrap on both sides; miss not-taken leaves table untouched.
        step(32'hFFFF_FFFC, 1,  32'hFFFF_FFFC, 0, 32'h0,      0,  32'h0,       0,  32'h0,     0,   32'h0);
        step(32'h22,        0,  32'h0,        0, 32'h0,       0,  32'h0,       1,  32'h90,    0,   32'h4);

        // Reset with an update presented: the update must be discarded.
        reset_cycle(32'h40, 1'b1, 32'h200);
        step(32'h20,        0,  32'h0,        0, 32'h0,       0,  32'h0,       0,  32'h24,    0,   32'h4);
        step(32'h60,        0,  32'h0,        0, 32'h0,       0,  32'h0,       0,  32'h64,    0,   32'h4);
        step(32'h40,        0,  32'h0,        0, 32'h0,       0,  32'h0,       0,  32'h44,    0,   32'h4);

        @(posedge clk);
        #1;
        chk = 1'b0;
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
